// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control and video-guard symbols, guard FSM states, disparity width.
package tmds_pkg;

  localparam int unsigned DispW = 5;

  localparam logic [9:0] Ctrl00 = 10'b1101010100;
  localparam logic [9:0] Ctrl01 = 10'b0010101011;
  localparam logic [9:0] Ctrl10 = 10'b0101010100;
  localparam logic [9:0] Ctrl11 = 10'b1010101011;

  localparam logic [9:0] GuardL0 = 10'b1011001100;
  localparam logic [9:0] GuardL1 = 10'b0100110011;
  localparam logic [9:0] GuardL2 = 10'b1011001100;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StGuard,
    StActive
  } guard_state_e;

  function automatic logic [9:0] ctrl_sym(input logic c1, input logic c0);
    logic [9:0] sym;
    unique case ({c1, c0})
      2'b00:   sym = Ctrl00;
      2'b01:   sym = Ctrl01;
      2'b10:   sym = Ctrl10;
      default: sym = Ctrl11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_encoder_array_if.sv
// Pixel-stream in / TMDS-symbol out bundle of the encoder array.
interface tmds_encoder_array_if #(
  parameter int unsigned NUM_CH = 3
);
  logic [8*NUM_CH-1:0]  video_din;
  logic                 video_hsync;
  logic                 video_vsync;
  logic                 video_de;
  logic [10*NUM_CH-1:0] tmds_dout;
  logic                 tmds_de;

  modport master (
    output video_din, video_hsync, video_vsync, video_de,
    input  tmds_dout, tmds_de
  );

  modport slave (
    input  video_din, video_hsync, video_vsync, video_de,
    output tmds_dout, tmds_de
  );
endinterface

// File: rtl/tmds_lane_enc.sv
// One TMDS lane: stage 1 builds the transition-minimised q_m, stage 2 DC-balances it
// or emits a control / forced symbol during blanking.
module tmds_lane_enc
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  input  logic       force_en,
  input  logic [9:0] force_sym,
  output logic [9:0] dout
);

  logic [3:0] n1_din;
  logic       use_xnor;
  logic       acc;
  logic [8:0] qm;

  always_comb begin
    n1_din = '0;
    for (int i = 0; i < 8; i++) n1_din = n1_din + 4'(din[i]);
    use_xnor = (n1_din > 4'd4) || ((n1_din == 4'd4) && !din[0]);
    qm       = '0;
    acc      = din[0];
    qm[0]    = acc;
    for (int i = 1; i < 8; i++) begin
      acc   = use_xnor ? ~(acc ^ din[i]) : (acc ^ din[i]);
      qm[i] = acc;
    end
    qm[8] = ~use_xnor;
  end

  logic [8:0] qm_q;
  logic       de_q, c0_q, c1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qm_q <= '0;
      de_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      qm_q <= qm;
      de_q <= de;
      c0_q <= c0;
      c1_q <= c1;
    end
  end

  logic [3:0]       n1_q;
  logic [DispW-1:0] bal;
  logic [DispW-1:0] cnt_q, cnt_d;
  logic [9:0]       dout_d;

  // bal = ones - zeros of q_m[7:0]; cnt is two's complement, sign in the MSB.
  // force_en/force_sym are aligned with stage 2, one cycle after din.
  always_comb begin
    n1_q = '0;
    for (int i = 0; i < 8; i++) n1_q = n1_q + 4'(qm_q[i]);
    bal    = DispW'({n1_q, 1'b0}) - DispW'(8);
    cnt_d  = cnt_q;
    dout_d = ctrl_sym(c1_q, c0_q);
    if (de_q) begin
      if ((cnt_q == '0) || (n1_q == 4'd4)) begin
        dout_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d  = qm_q[8] ? cnt_q + bal : cnt_q - bal;
      end else if ((!cnt_q[DispW-1] && (n1_q > 4'd4)) || (cnt_q[DispW-1] && (n1_q < 4'd4))) begin
        dout_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d  = cnt_q + (qm_q[8] ? DispW'(2) : DispW'(0)) - bal;
      end else begin
        dout_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d  = cnt_q - (qm_q[8] ? DispW'(0) : DispW'(2)) + bal;
      end
    end else begin
      cnt_d = '0;
      if (force_en) dout_d = force_sym;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dout  <= Ctrl00;
    end else begin
      cnt_q <= cnt_d;
      dout  <= dout_d;
    end
  end

endmodule

// File: rtl/tmds_encoder_array.sv
// NUM_CH-lane TMDS encoder with fixed PREAMBLE_LEN+GUARD_LEN+2 latency. Define HDMI_GUARD_EN to
// insert the HDMI video preamble and guard band ahead of each active line (requires NUM_CH = 3).
module tmds_encoder_array
  import tmds_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned GUARD_LEN    = 2
) (
  input  logic                 pclk,
  input  logic                 reset,
  tmds_encoder_array_if.slave  vid
);

  localparam int unsigned D    = PREAMBLE_LEN + GUARD_LEN;
  localparam int unsigned RecW = 8 * NUM_CH + 3;

  // Delay line: the FSM sees the de edge D cycles before the lanes do.
  logic [RecW-1:0] dly_q [D];

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < D; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= {vid.video_de, vid.video_vsync, vid.video_hsync, vid.video_din};
      for (int i = 1; i < D; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  logic                de_dly, vs_dly, hs_dly;
  logic [8*NUM_CH-1:0] din_dly;

  assign {de_dly, vs_dly, hs_dly, din_dly} = dly_q[D-1];

  logic [NUM_CH-1:0] force_en;
  logic [9:0]        force_sym [NUM_CH];

`ifdef HDMI_GUARD_EN
  localparam int unsigned MaxLen = (PREAMBLE_LEN > GUARD_LEN) ? PREAMBLE_LEN : GUARD_LEN;
  localparam int unsigned CntW   = $clog2(MaxLen) + 1;

  guard_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            de_in_q, de_dly_q;
  logic            de_rise, de_dly_fall;

  assign de_rise     = vid.video_de & ~de_in_q;
  assign de_dly_fall = de_dly_q & ~de_dly;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      de_in_q  <= 1'b0;
      de_dly_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      de_in_q  <= vid.video_de;
      de_dly_q <= de_dly;
    end
  end

  // Overrides come from state_q and hit stage 2, where the matching slot sits in stage 1.
  // A new line always restarts the sequence, even while the previous line is still draining.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    force_en = '0;
    for (int k = 0; k < NUM_CH; k++) force_sym[k] = Ctrl00;

    if (de_rise) begin
      state_d = StPre;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPre: begin
          if (cnt_q == CntW'(PREAMBLE_LEN - 1)) begin
            state_d = StGuard;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StGuard: begin
          if (cnt_q == CntW'(GUARD_LEN - 1)) begin
            state_d = StActive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StActive: if (de_dly_fall) state_d = StIdle;
      endcase
    end

    unique case (state_q)
      StPre: begin
        force_en[1]  = 1'b1;
        force_sym[1] = Ctrl01;
        force_en[2]  = 1'b1;
        force_sym[2] = Ctrl00;
      end
      StGuard: begin
        force_en     = '1;
        force_sym[0] = GuardL0;
        force_sym[1] = GuardL1;
        force_sym[2] = GuardL2;
      end
      default: ;
    endcase
  end
`else
  always_comb begin
    force_en = '0;
    for (int k = 0; k < NUM_CH; k++) force_sym[k] = Ctrl00;
  end
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [9:0] lane_dout;

    tmds_lane_enc u_enc (
      .clk       (pclk),
      .rst       (reset),
      .din       (din_dly[8*k +: 8]),
      .c0        ((k == 0) ? hs_dly : 1'b0),
      .c1        ((k == 0) ? vs_dly : 1'b0),
      .de        (de_dly),
      .force_en  (force_en[k]),
      .force_sym (force_sym[k]),
      .dout      (lane_dout)
    );

    assign vid.tmds_dout[10*k +: 10] = lane_dout;
  end

  logic de_s1_q;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      de_s1_q     <= 1'b0;
      vid.tmds_de <= 1'b0;
    end else begin
      de_s1_q     <= de_dly;
      vid.tmds_de <= de_s1_q;
    end
  end

endmodule
